key_sel2_ctrl: RTL
==================

KEY_SEL2_CTRL -- requirements
Module: key_sel2_ctrl

Interface
REQ-001 Parameter DB_CNT, default 240000, number of consecutive clock edges a synchronized key level must differ from the debounced level before it is accepted (20 ms at 12 MHz); legal range 2..2^20-1.
REQ-002 Port clk  input  1  system clock, all flops rising-edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port key_up_n  input  1  push button, asynchronous to clk, active-low (0 = pressed).
REQ-005 Port key_dn_n  input  1  push button, asynchronous to clk, active-low (0 = pressed).
REQ-006 Port sel  output  2  registered 2-bit select code, drives the a input of the 2-to-4 LED decoder.
REQ-007 Port sel_chg  output  1  registered one-cycle pulse, high in the cycle sel first shows a new value.
REQ-008 One clock; reset asynchronous, active-low, on rst_n; clock port clk.

Function
REQ-009 Each key input passes through a 2-flop synchronizer before any other logic; no combinational path from key pins to outputs.
REQ-010 Each key has an independent debouncer: debounced level db (reset 1 = released), counter cnt (20 bits, reset 0).
REQ-011 Debouncer: synchronized level equal to db -> cnt cleared to 0 on that edge; differs -> cnt increments.
REQ-012 Debouncer: on the edge where the level has differed for DB_CNT consecutive edges (cnt == DB_CNT-1 and still differing), db takes the synchronized level and cnt clears.
REQ-013 Any glitch shorter than DB_CNT edges (level returns to db) restarts the count; no press is generated.
REQ-014 Press event = db transition 1->0 only; release (0->1) generates no event; holding a key generates exactly one event.
REQ-015 Up event alone: sel <= sel+1 modulo 4 (3 wraps to 0).
REQ-016 Down event alone: sel <= sel-1 modulo 4 (0 wraps to 3).
REQ-017 Up and down events on the same edge: sel unchanged, sel_chg stays 0.
REQ-018 sel and sel_chg update on the edge after the db transition; exact latency: if edge 1 is the first edge sampling the key low and the key stays low, sel changes at edge DB_CNT+3.
REQ-019 sel_chg = 1 for exactly one cycle per accepted sel change, 0 otherwise.
REQ-020 Second key pressed while the first is held: its own event is processed normally per REQ-015/016.

Reset
REQ-021 rst_n low: sel = 2'b00, sel_chg = 0, both db = 1, both cnt = 0, synchronizer flops = 1, immediately and independent of clk.
REQ-022 rst_n asserted mid-debounce: partial count discarded; after release, a key already held low is treated as a new press and produces one event after the full REQ-018 latency.
REQ-023 No event on reset release with both keys high.

Verification (bench uses DB_CNT = 4)
REQ-024 Reset, keys high, 20 cycles -> sel = 00, sel_chg never 1.
REQ-025 key_up_n low held 20 cycles, four times with release -> sel 01, 10, 11, 00 (wrap), each change exactly 7 edges after first low sample, one sel_chg pulse per press.
REQ-026 From sel = 00, key_dn_n press -> sel = 11 (wrap down), single sel_chg pulse; holding 50 cycles gives no further change.
REQ-027 key_up_n bounce: low 3 cycles, high 1, low 2, high -> sel unchanged, sel_chg 0; then stable low -> exactly one increment.
REQ-028 Both keys driven low on the same cycle from sel = 10 -> sel stays 10, sel_chg 0; up pressed while down held -> sel = 11.
REQ-029 rst_n pulsed low at cnt = 2 during an up press, key kept low -> sel = 00 immediately; after rst_n high, sel = 01 exactly 7 edges later.

Source files
------------

// File: rtl/key_sel2_ctrl.sv
// Two debounced push buttons step a 2-bit LED select code up or down (mod 4).
// sel_chg pulses for one cycle whenever sel takes a new value.
module key_sel2_ctrl #(
  parameter int DB_CNT = 240000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic [1:0] sel,
  output logic       sel_chg
);

  localparam logic [19:0] CNT_LAST = 20'(DB_CNT - 1);

  // Index 0 = up key, index 1 = down key.
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  db;
  logic [19:0] cnt [2];
  logic [1:0]  press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {key_dn_n, key_up_n};
      sync2 <= sync1;
    end
  end

  // press is registered alongside the db update so sel moves on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
      press  <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          cnt[k]   <= '0;
          db[k]    <= sync2[k];
          press[k] <= ~sync2[k];
        end else begin
          cnt[k] <= cnt[k] + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 2'b00;
      sel_chg <= 1'b0;
    end else begin
      case (press)
        2'b01: begin
          sel     <= sel + 2'd1;
          sel_chg <= 1'b1;
        end
        2'b10: begin
          sel     <= sel - 2'd1;
          sel_chg <= 1'b1;
        end
        default: sel_chg <= 1'b0;
      endcase
    end
  end

endmodule
